fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_rd_pkg.sv | 35 +++
 rtl/fifo_rd_skid.sv | 57 +++++
 rtl/fifo_rd_adapter.sv | 73 +++++++
 tb/tb_fifo_rd_adapter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read adapter and its output buffer.
package fifo_rd_pkg;

    localparam int DEFAULT_DW = 8;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Next FSM state; 'drained' means no buffered word and no read in flight.
    function automatic state_t next_state(input state_t cur, input logic enable,
                                          input logic drained);
        state_t nxt;
        nxt = cur;
        case (cur)
            IDLE:    nxt = enable ? RUN : IDLE;
            RUN:     nxt = enable ? RUN : FLUSH;
            FLUSH: begin
                if (enable) begin
                    nxt = RUN;
                end else if (drained) begin
                    nxt = IDLE;
                end else begin
                    nxt = FLUSH;
                end
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: a tiny circular queue with a head pointer and an
// occupancy count. Push and pop in the same cycle keep occupancy unchanged.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head_data
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          head_q, head_d;
    logic [1:0]    occ_q, occ_d;
    logic          pop_ok, push_ok, wr_idx;

    // Work out the write slot (head + occupancy, modulo 2) and the next head/occupancy.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        occ_d   = occ_q;
        pop_ok  = pop && (occ_q != 2'd0);
        push_ok = push && ((occ_q != 2'd2) || pop_ok);
        wr_idx  = head_q ^ occ_q[0];
        if (push_ok) begin
            mem_d[wr_idx] = push_data;
        end
        if (pop_ok) begin
            head_d = ~head_q;
        end
        occ_d = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // Storage, head pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            occ_q    <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream. Reads are
// only issued when the word they fetch is guaranteed a buffer slot on arrival.
module fifo_rd_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_data_out,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             infl_q, infl_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [1:0]       occ;
    logic [DW-1:0]    head_data;
    logic             pop;
    logic [2:0]       level;
    logic             drained;

    // Outputs are held low while reset is asserted, even before the first edge.
    assign m_valid  = reset && (occ != 2'd0);
    assign pop      = m_valid && m_ready;
    assign level    = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    assign fifo_rd  = reset && (state_q == RUN) && !fifo_empty && (level < 3'(BUF_DEPTH));
    assign drained  = (occ == 2'd0) && !infl_q;
    assign m_data   = m_valid ? head_data : '0;
    assign busy     = reset && (state_q != IDLE);
    assign rd_count = rd_count_q;

    // Next state, in-flight flag (a read this cycle lands next cycle) and delivered-word count.
    always_comb begin
        state_d    = next_state(state_q, enable, drained);
        infl_d     = fifo_rd;
        rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, pop};
    end

    // FSM, in-flight tracking and counter registers; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            infl_q     <= 1'b0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            infl_q     <= infl_d;
            rd_count_q <= rd_count_d;
        end
    end

    fifo_rd_skid #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (infl_q),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a queue-based FIFO, a word-level reference model
// and directed scenarios with hand-computed expectations.
module tb_fifo_rd_adapter;

    localparam int DW      = 8;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [15:0]   rd_count;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // FIFO contents and the reference model: words read but not yet delivered, with read cycle
    logic [7:0] fifo_q[$];
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    int         cyc        = 0;
    int         mstate     = M_IDLE;
    int         total_pops = 0;

    // Per-cycle events recorded at the falling edge, applied at the rising edge
    logic ev_rst = 1'b1;
    logic ev_pop = 1'b0;
    logic ev_rd  = 1'b0;
    logic ev_en  = 1'b0;
    int   ev_out = 0;

    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] env_word;

    // Scenario logs
    logic [7:0] got[$];
    int         got_cyc[$];
    int         rd_pulses    = 0;
    int         first_rd_cyc = -1;
    int         valid_cycles = 0;

    logic [15:0] exp_wrap [3] = '{16'hFFFF, 16'h0000, 16'h0001};

    always #5 clk = ~clk;

    fifo_rd_adapter #(
        .DW        (DW),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd       (fifo_rd),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .rd_count      (rd_count),
        .busy          (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic rdy_v);
        @(posedge clk);
        #1;
        reset   = rst_v;
        enable  = en_v;
        m_ready = rdy_v;
    endtask

    task automatic fifo_push(input logic [7:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        got.delete();
        got_cyc.delete();
        rd_pulses    = 0;
        first_rd_cyc = -1;
        valid_cycles = 0;
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        fifo_q.delete();
        fifo_empty = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        clear_logs();
    endtask

    // FIFO environment and model update on every rising edge
    initial begin : env_proc
        forever begin
            @(posedge clk);
            env_word = 8'hEE;
            if (ev_rst) begin
                exp_data.delete();
                exp_cyc.delete();
                total_pops = 0;
                mstate     = M_IDLE;
            end else begin
                if (ev_pop && exp_data.size() > 0) begin
                    void'(exp_data.pop_front());
                    void'(exp_cyc.pop_front());
                    total_pops++;
                end
                case (mstate)
                    M_IDLE:  if (ev_en) mstate = M_RUN;
                    M_RUN:   if (!ev_en) mstate = M_FLUSH;
                    default: begin
                        if (ev_en) mstate = M_RUN;
                        else if (ev_out == 0) mstate = M_IDLE;
                    end
                endcase
            end
            if (ev_rd && fifo_q.size() > 0) begin
                env_word = fifo_q.pop_front();
                if (!ev_rst) begin
                    exp_data.push_back(env_word);
                    exp_cyc.push_back(cyc);
                end
            end
            cyc++;
            #1;
            fifo_data_out = env_word;
            fifo_empty    = (fifo_q.size() == 0);
        end
    end

    // Compare the DUT against the model on every cycle
    always @(negedge clk) begin : compare_proc
        logic exp_valid, exp_pop, exp_rd;
        int   outstanding;
        outstanding = 0;
        if (!reset) begin
            checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
            checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
            checkOutput("rst_m_data",  32'(m_data),  32'd0);
            checkOutput("rst_busy",    32'(busy),    32'd0);
            hold_prev = 1'b0;
            ev_pop    = 1'b0;
            ev_rd     = 1'b0;
        end else begin
            outstanding = exp_data.size();
            exp_valid   = 1'b0;
            if (outstanding > 0) begin
                exp_valid = (exp_cyc[0] + 2 <= cyc);
            end
            exp_pop = exp_valid && m_ready;
            exp_rd  = (mstate == M_RUN) && !fifo_empty &&
                      ((outstanding - (exp_pop ? 1 : 0)) < 2);
            checkOutput("m_valid", 32'(m_valid), 32'(exp_valid));
            if (exp_valid) begin
                checkOutput("m_data", 32'(m_data), 32'(exp_data[0]));
            end
            checkOutput("fifo_rd",  32'(fifo_rd),  32'(exp_rd));
            checkOutput("busy",     32'(busy),     32'(mstate != M_IDLE));
            checkOutput("rd_count", 32'(rd_count), 32'(total_pops[15:0]));
            if (hold_prev) begin
                checkOutput("hold_valid", 32'(m_valid), 32'd1);
                checkOutput("hold_data",  32'(m_data),  32'(hold_data));
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            ev_pop    = exp_pop;
            ev_rd     = fifo_rd;
        end
        ev_rst = !reset;
        ev_en  = enable;
        ev_out = outstanding;
    end

    // Scenario logging of deliveries, read strobes and valid cycles
    always @(negedge clk) begin : log_proc
        if (reset) begin
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            if (fifo_rd) begin
                rd_pulses++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (m_valid) valid_cycles++;
        end
    end

    initial begin : stim_proc
        int guard;
        reset         = 1'b0;
        enable        = 1'b0;
        m_ready       = 1'b0;
        fifo_empty    = 1'b1;
        fifo_data_out = 8'h00;

        // Reset state
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_busy",    32'(busy),    32'd0);
        checkOutput("reset_fifo_rd", 32'(fifo_rd), 32'd0);

        // Streaming 0x01..0x10 with the sink always ready
        do_reset();
        for (int i = 1; i <= 16; i++) fifo_push(8'(i));
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("stream_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got.size()) checkOutput("stream_word", 32'(got[i]), 32'(i + 1));
        end
        if (got.size() == 16) begin
            checkOutput("stream_latency",    32'(got_cyc[0] - first_rd_cyc), 32'd2);
            checkOutput("stream_back2back",  32'(got_cyc[15] - got_cyc[0]), 32'd15);
        end
        @(negedge clk);
        checkOutput("stream_rd_count", 32'(rd_count), 32'd16);

        // Backpressure: sink stalled for 10 cycles
        do_reset();
        for (int i = 0; i < 8; i++) fifo_push(8'hA0 + 8'(i));
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_valid", 32'(m_valid), 32'd1);
        checkOutput("bp_data",  32'(m_data),  32'hA0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        repeat (15) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("bp_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) checkOutput("bp_word", 32'(got[i]), 32'hA0 + 32'(i));
        end

        // Empty FIFO with enable high
        do_reset();
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("empty_busy", 32'(busy), 32'd1);

        // Flush: drop enable with one word buffered and one in flight
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("empty_rd_pulses", 32'(rd_pulses),    32'd0);
        checkOutput("empty_valid",     32'(valid_cycles), 32'd0);
        fifo_push(8'hB0);
        fifo_push(8'hB1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_valid_at_drop", 32'(m_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        fifo_push(8'hB2);
        fifo_push(8'hB3);
        repeat (7) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("flush_rd_pulses", 32'(rd_pulses), 32'd2);
        checkOutput("flush_count",     32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            checkOutput("flush_word0", 32'(got[0]), 32'hB0);
            checkOutput("flush_word1", 32'(got[1]), 32'hB1);
        end
        @(negedge clk);
        checkOutput("flush_busy", 32'(busy), 32'd0);

        // Mid-run reset with a full buffer
        do_reset();
        for (int i = 0; i < 8; i++) fifo_push(8'hC0 + 8'(i));
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("mid_pre_valid",    32'(m_valid),  32'd1);
        checkOutput("mid_pre_data",     32'(m_data),   32'hC2);
        checkOutput("mid_pre_rd_count", 32'(rd_count), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mid_post_valid",    32'(m_valid),  32'd0);
        checkOutput("mid_post_rd_count", 32'(rd_count), 32'd0);
        clear_logs();

        // Reset while a read is in flight: its word must never appear
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("infl_rd_pulses", 32'(rd_pulses),    32'd1);
        checkOutput("infl_valid",     32'(valid_cycles), 32'd0);
        checkOutput("infl_count",     32'(got.size()),   32'd0);

        // Counter wrap: stream up to 0xFFFE, then three single pops
        do_reset();
        guard = 0;
        while (total_pops < 65534 && guard < 70000) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            m_ready = (total_pops < 65534);
            if (fifo_q.size() < 4) fifo_push(guard[7:0]);
            guard++;
        end
        @(negedge clk);
        checkOutput("wrap_start", 32'(rd_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("wrap_seq", 32'(rd_count), 32'(exp_wrap[k]));
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
